gf163_serial_mult: RTL and testbench

GF163_SERIAL_MULT -- requirements
Module: gf163_serial_mult

---
 rtl/gf163_pkg.sv | 33 +++
 rtl/gf163_serial_mult_if.sv | 18 +
 rtl/gf163_digit_pp.sv | 34 +++
 rtl/gf163_serial_mult.sv | 118 +++++++++++
 tb/tb_gf163_serial_mult.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf163_pkg.sv
// gf163_pkg -- shared definitions for the GF(2^163) digit-serial multiplier.
//   M        : field degree (operand width)
//   PROD_W   : width of the unreduced carry-less product (2*M-1)
//   state_t  : controller states
//   ndig()   : number of multiplier digits for a given digit width
//   spread() : bit-spread of an operand, which is its square over GF(2)
package gf163_pkg;

  localparam int M      = 163;
  localparam int PROD_W = 325;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(M / digit)
  function automatic int ndig(input int digit);
    return (M + digit - 1) / digit;
  endfunction

  // Squaring in GF(2)[x] has no cross terms: coefficient i moves to 2i.
  function automatic logic [PROD_W-1:0] spread(input logic [M-1:0] x);
    logic [PROD_W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      r[2*i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf163_serial_mult_if.sv
// gf163_serial_mult_if -- request/result bundle of the serial multiplier.
//   start, a, b, sq : request side (driven by master)
//   busy, done, p   : status and unreduced product (driven by slave)
interface gf163_serial_mult_if;
  import gf163_pkg::*;

  logic              start;
  logic [M-1:0]      a;
  logic [M-1:0]      b;
  logic              sq;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] p;

  modport master (output start, a, b, sq, input busy, done, p);
  modport slave  (input start, a, b, sq, output busy, done, p);

endinterface

// File: rtl/gf163_digit_pp.sv
// gf163_digit_pp -- combinational carry-less partial product of a 163-bit
// operand and a DIGIT-bit digit.
//   a_i  : 163-bit multiplicand
//   d_i  : DIGIT-bit multiplier digit
//   pp_o : (163+DIGIT-1)-bit product a_i * d_i over GF(2)
module gf163_digit_pp
  import gf163_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [M-1:0]       a_i,
  input  logic [DIGIT-1:0]   d_i,
  output logic [M+DIGIT-2:0] pp_o
);

  localparam int W = M + DIGIT - 1;

  logic [W-1:0] a_ext;
  logic [W-1:0] term [DIGIT];

  assign a_ext = W'(a_i);

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_term
    assign term[gi] = d_i[gi] ? (a_ext << gi) : '0;
  end

  always_comb begin
    pp_o = '0;
    for (int j = 0; j < DIGIT; j++) begin
      pp_o = pp_o ^ term[j];
    end
  end

endmodule

// File: rtl/gf163_serial_mult.sv
// gf163_serial_mult -- digit-serial carry-less multiplier for GF(2^163)
// operands, producing the unreduced 325-bit product.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gf163_serial_mult_if.slave (start/a/b/sq in, busy/done/p out)
// Parameter DIGIT (1, 2, 4 or 8): multiplier bits consumed per RUN cycle.
// Macro GF163_MUL_SQUARE_FAST_EN: when defined, a squaring request skips RUN
// and loads the bit-spread of a directly; otherwise squaring runs the normal
// digit-serial sequence with b replaced by a.
// Latency: done is high NDIG+1 cycles after the edge that accepted start
// (1 cycle for a fast square); p holds until the next done.
module gf163_serial_mult
  import gf163_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  gf163_serial_mult_if.slave bus
);

  localparam int NDIG  = ndig(DIGIT);
  localparam int BPAD  = NDIG * DIGIT;  // b zero-padded at the MSB end
  localparam int PP_W  = M + DIGIT - 1;
  localparam int CNT_W = 8;             // NDIG <= 163 for DIGIT >= 1

  state_t             state_q, state_d;
  logic [M-1:0]       a_q, a_d;
  logic [BPAD-1:0]    b_q, b_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic               done_q, done_d;
  logic [PP_W-1:0]    pp;

  // The current digit is always the top DIGIT bits of b_q; b_q shifts left
  // each RUN cycle so digits come out MSB-first.
  gf163_digit_pp #(.DIGIT(DIGIT)) u_pp (
    .a_i  (a_q),
    .d_i  (b_q[BPAD-1 -: DIGIT]),
    .pp_o (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = BPAD'(bus.sq ? bus.a : bus.b);
          acc_d   = '0;
          cnt_d   = CNT_W'(NDIG);
          state_d = RUN;
`ifdef GF163_MUL_SQUARE_FAST_EN
          if (bus.sq) begin
            acc_d   = spread(bus.a);
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        // Product degree never exceeds 324, so nothing shifts out the top
        // of the accumulator before the last digit.
        acc_d = (acc_q << DIGIT) ^ PROD_W'(pp);
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        p_d     = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_gf163_serial_mult.sv
// tb_gf163_serial_mult -- self-checking bench for gf163_serial_mult.
// Expected products come from a bit-serial software carry-less multiply and
// are queued when a request is issued, then popped when done is observed.
// DIGIT may be set to 1, 4 or 8; latency expectations follow from it.
module tb_gf163_serial_mult;

  localparam int DIGIT   = 4;
  localparam int NDIG_TB = (163 + DIGIT - 1) / DIGIT;
  localparam int LIMIT   = NDIG_TB + 20;
`ifdef GF163_MUL_SQUARE_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  gf163_serial_mult_if bus ();

  gf163_serial_mult #(.DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  logic [324:0] sb_q [$];

  // Counts done cycles, sampled at the edge that ends each cycle.
  always @(posedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  function automatic logic [324:0] clmul(input logic [162:0] x, input logic [162:0] y);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++) begin
      if (y[i]) r = r ^ ({162'b0, x} << i);
    end
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[162:0];
  endfunction

  function automatic int lat_exp(input logic s);
    return (FAST && s) ? 1 : NDIG_TB + 1;
  endfunction

  // Drives one request for a single cycle and queues its expected product.
  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [162:0] ta, input logic [162:0] tb_v, input logic tsq);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.sq    = tsq;
    sb_q.push_back(tsq ? clmul(ta, ta) : clmul(ta, tb_v));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = rand163();
    bus.b     = rand163();
    bus.sq    = 1'b0;
  endtask

  // Counts cycles since the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (cyc <= LIMIT) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sq    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.p !== 325'd0) begin
      errors++; $display("FAIL reset_p got=%h want=0", bus.p);
    end
    rst = 1'b0;  // the next edge already carries the first request
  endtask

  task automatic test_basic();
    logic [162:0] ta [5];
    logic [162:0] tb_v [5];
    logic [324:0] exp_p;
    int cyc;
    bit ok;
    ta[0] = 163'd1;       tb_v[0] = 163'd1;
    ta[1] = 163'h3;       tb_v[1] = 163'h3;
    ta[2] = 163'h7;       tb_v[2] = 163'h3;
    ta[3] = 163'd1 << 162; tb_v[3] = 163'd1 << 162;
    ta[4] = '1;           tb_v[4] = 163'd1;
    for (int k = 0; k < 5; k++) begin
      issue(ta[k], tb_v[k], 1'b0);
      wait_done(cyc, ok);
      exp_p = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL basic%0d_timeout got=no_done want=done", k);
      end else begin
        checks++;
        if (cyc != lat_exp(1'b0)) begin
          errors++; $display("FAIL basic%0d_latency got=%0d want=%0d", k, cyc, lat_exp(1'b0));
        end
        checks++;
        if (bus.p !== exp_p) begin
          errors++; $display("FAIL basic%0d_p got=%h want=%h", k, bus.p, exp_p);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
          errors++; $display("FAIL basic%0d_pulse got=%b want=0", k, bus.done);
        end
      end
      $display("txn basic%0d a=%h b=%h p=%h lat=%0d", k, ta[k], tb_v[k], bus.p, cyc);
    end
    // Spot values that do not depend on the model.
    checks++;
    if (clmul(163'h7, 163'h3) !== 325'h9 || clmul(163'h3, 163'h3) !== 325'h5) begin
      errors++; $display("FAIL model_sanity got=bad want=5/9");
    end
  endtask

  task automatic test_busy_ignore();
    logic [162:0] ta, tb_v;
    logic [324:0] exp_p;
    int d0, cyc;
    bit ok;
    ta = rand163(); tb_v = rand163();
    d0 = done_seen;
    issue(ta, tb_v, 1'b0);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = rand163();
    bus.b     = rand163();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL ignore_busy got=%b want=1", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, ok);
    exp_p = sb_q.pop_front();
    checks++;
    if (!ok || bus.p !== exp_p) begin
      errors++; $display("FAIL ignore_p got=%h want=%h", bus.p, exp_p);
    end
    checks++;
    if (cyc != lat_exp(1'b0) - 10) begin
      errors++; $display("FAIL ignore_latency got=%0d want=%0d", cyc + 10, lat_exp(1'b0));
    end
    repeat (NDIG_TB + 5) @(negedge clk);
    checks++;
    if (done_seen - d0 != 1) begin
      errors++; $display("FAIL ignore_done_count got=%0d want=1", done_seen - d0);
    end
    checks++;
    if (bus.p !== exp_p) begin
      errors++; $display("FAIL ignore_hold got=%h want=%h", bus.p, exp_p);
    end
    $display("txn ignore a=%h b=%h p=%h dones=%0d", ta, tb_v, bus.p, done_seen - d0);
  endtask

  task automatic test_reset_mid_run();
    logic [162:0] ta, tb_v;
    logic [324:0] exp_p;
    int d0, cyc;
    bit ok;
    issue(rand163(), rand163(), 1'b0);
    void'(sb_q.pop_front());
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_flags got=busy%b/done%b want=0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.p !== 325'd0) begin
      errors++; $display("FAIL abort_p got=%h want=0", bus.p);
    end
    d0 = done_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (NDIG_TB + 5) @(negedge clk);
    checks++;
    if (done_seen != d0) begin
      errors++; $display("FAIL abort_no_done got=%0d want=0", done_seen - d0);
    end
    ta = rand163(); tb_v = rand163();
    issue(ta, tb_v, 1'b0);
    wait_done(cyc, ok);
    exp_p = sb_q.pop_front();
    checks++;
    if (!ok || bus.p !== exp_p || cyc != lat_exp(1'b0)) begin
      errors++; $display("FAIL abort_restart got=%h lat=%0d want=%h lat=%0d", bus.p, cyc, exp_p, lat_exp(1'b0));
    end
    $display("txn abort_restart a=%h b=%h p=%h lat=%0d", ta, tb_v, bus.p, cyc);
  endtask

  task automatic test_square();
    logic [162:0] ta [3];
    logic [324:0] exp_p;
    int cyc;
    bit ok;
    ta[0] = 163'h5; ta[1] = rand163(); ta[2] = '1;
    for (int k = 0; k < 3; k++) begin
      issue(ta[k], rand163(), 1'b1);  // b is garbage and must be ignored
      wait_done(cyc, ok);
      exp_p = sb_q.pop_front();
      if (k == 0) exp_p = 325'h11;
      checks++;
      if (!ok || bus.p !== exp_p) begin
        errors++; $display("FAIL square%0d_p got=%h want=%h", k, bus.p, exp_p);
      end
      checks++;
      if (cyc != lat_exp(1'b1)) begin
        errors++; $display("FAIL square%0d_latency got=%0d want=%0d", k, cyc, lat_exp(1'b1));
      end
      $display("txn square%0d a=%h p=%h lat=%0d", k, ta[k], bus.p, cyc);
    end
  endtask

  task automatic test_random();
    logic [162:0] ta, tb_v;
    logic [324:0] exp_p;
    int cyc;
    bit ok;
    for (int k = 0; k < 8; k++) begin
      ta = rand163(); tb_v = rand163();
      issue(ta, tb_v, 1'b0);
      wait_done(cyc, ok);
      exp_p = sb_q.pop_front();
      checks++;
      if (!ok || bus.p !== exp_p || cyc != lat_exp(1'b0)) begin
        errors++; $display("FAIL random%0d got=%h lat=%0d want=%h lat=%0d", k, bus.p, cyc, exp_p, lat_exp(1'b0));
      end
      $display("txn random%0d a=%h b=%h p=%h lat=%0d", k, ta, tb_v, bus.p, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [162:0] ta [3];
    logic [162:0] tb_v [3];
    logic [324:0] exp_p, prev_p;
    int cyc;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      ta[k] = rand163(); tb_v[k] = rand163();
    end
    prev_p = '0;
    issue(ta[0], tb_v[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc, ok);
      exp_p = sb_q.pop_front();
      checks++;
      if (!ok || bus.p !== exp_p || cyc != lat_exp(1'b0)) begin
        errors++; $display("FAIL b2b%0d got=%h lat=%0d want=%h lat=%0d", k, bus.p, cyc, exp_p, lat_exp(1'b0));
      end
      $display("txn b2b%0d a=%h b=%h p=%h lat=%0d", k, ta[k], tb_v[k], bus.p, cyc);
      prev_p = exp_p;
      // Next request is presented during the done cycle itself.
      if (k < 2) begin
        issue(ta[k+1], tb_v[k+1], 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.p !== prev_p) begin
          errors++; $display("FAIL b2b%0d_accept got=busy%b p=%h want=busy1 p=%h", k, bus.busy, bus.p, prev_p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_reset_mid_run();
    test_square();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
